// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment glyph table for the display-capture monitor.
package seg7_pkg;

  // Active-high gfedcba patterns, index = hex value; entry 15 sits at the MSB end.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  function automatic logic an_single(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic digit_idx_t an_to_idx(input logic [3:0] an);
    digit_idx_t idx;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_capture_4_7_if.sv
// Display-line and result bundle for seg_capture_4_7; master drives the scanned lines.
interface seg_capture_4_7_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] binary_num;
  logic        frame_valid;
  logic        decode_err;
  logic        locked;
  logic [3:0]  dp_flags;

  modport master (
    output an, seg, dp,
    input  binary_num, frame_valid, decode_err, locked, dp_flags
  );

  modport slave (
    input  an, seg, dp,
    output binary_num, frame_valid, decode_err, locked, dp_flags
  );
endinterface

// File: rtl/segment_to_binary.sv
// Reverse lookup of an active-high 7-segment pattern to its hex nibble.
module segment_to_binary
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_capture_4_7.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment display; rebuilds the shown value.
// Optional SEG_CAPTURE_DP_EN captures per-digit decimal points into dp_flags.
module seg_capture_4_7
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst_n,
  seg_capture_4_7_if.slave bus
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

  logic [3:0] an_p0, an_p1, an_p2;
  logic [6:0] seg_p0, seg_p1, seg_p2;
  logic       stable;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt, settle_nxt;
  logic [3:0]      hold_an;
  logic            sample_en, sample_ok, multi_err, err_latch;
  logic            single, multi;
  digit_idx_t      idx;
  logic [3:0]      nibble;
  logic            nib_valid;

  logic [3:0][3:0] shadow;
  logic [3:0]      seen;
  logic            frame_pend;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     binary_num_q;
  logic            frame_valid_q, decode_err_q, locked_q;

  // Stage p0/p1: two-flop synchronizer; p2: previous cycle for the stability compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0  <= 4'hF;
      an_p1  <= 4'hF;
      an_p2  <= 4'hF;
      seg_p0 <= 7'h7F;
      seg_p1 <= 7'h7F;
      seg_p2 <= 7'h7F;
    end else begin
      an_p0  <= bus.an;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
      seg_p0 <= bus.seg;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic       dp_p0, dp_p1, dp_p2;
  logic [3:0] dp_shadow, dp_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_p0      <= 1'b1;
      dp_p1      <= 1'b1;
      dp_p2      <= 1'b1;
      dp_shadow  <= '0;
      dp_flags_q <= '0;
    end else begin
      dp_p0 <= bus.dp;
      dp_p1 <= dp_p0;
      dp_p2 <= dp_p1;
      if (sample_ok) dp_shadow[idx] <= ~dp_p1;
      if (frame_pend) dp_flags_q <= dp_shadow;
    end
  end

  assign stable       = ({an_p1, seg_p1, dp_p1} == {an_p2, seg_p2, dp_p2});
  assign bus.dp_flags = dp_flags_q;
`else
  logic unused_dp;
  assign unused_dp    = bus.dp;
  assign stable       = ({an_p1, seg_p1} == {an_p2, seg_p2});
  assign bus.dp_flags = 4'b0000;
`endif

  assign single    = an_single(an_p1);
  assign multi     = !single && (an_p1 != 4'hF);
  assign idx       = an_to_idx(an_p1);
  assign sample_ok = sample_en && nib_valid;

  segment_to_binary u_dec (
    .pattern (~seg_p1),
    .nibble  (nibble),
    .valid   (nib_valid)
  );

  // A multi-anode error is reported from IDLE, once until the anodes leave that state
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    sample_en  = 1'b0;
    multi_err  = 1'b0;
    case (state)
      IDLE: begin
        if (single) begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
        end else if (multi && !err_latch) begin
          multi_err = 1'b1;
        end
      end
      SETTLE: begin
        if (!single) begin
          state_nxt = IDLE;
        end else if (!stable) begin
          settle_nxt = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          sample_en = 1'b1;
          state_nxt = HOLD;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (an_p1 != hold_an) begin
          state_nxt  = single ? SETTLE : IDLE;
          settle_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      hold_an    <= 4'hF;
      err_latch  <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      err_latch  <= multi && (err_latch || multi_err);
      if (sample_en) hold_an <= an_p1;
    end
  end

  // Stage p3: sample commit, frame close one cycle later, lock timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= '0;
      seen          <= '0;
      frame_pend    <= 1'b0;
      to_cnt        <= '0;
      binary_num_q  <= '0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_pend    <= 1'b0;
      decode_err_q  <= multi_err || (sample_en && !nib_valid);
      if (frame_pend) begin
        binary_num_q  <= shadow;
        frame_valid_q <= 1'b1;
        locked_q      <= 1'b1;
        seen          <= '0;
      end
      if (sample_ok) begin
        shadow[idx] <= nibble;
        seen[idx]   <= 1'b1;
        to_cnt      <= TIMEOUT_LOAD;
        frame_pend  <= (idx == 2'd0) && ((seen | 4'b0001) == 4'hF);
      end else if (to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
        if (to_cnt == TW'(1)) begin
          locked_q <= 1'b0;
          seen     <= '0;
        end
      end
    end
  end

  assign bus.binary_num  = binary_num_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.decode_err  = decode_err_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_seg_capture_4_7.sv
// Scoreboard bench for seg_capture_4_7: directed scans, expected frames queued, monitor compares.
module tb_seg_capture_4_7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_capture_4_7_if bus ();

  seg_capture_4_7 #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(2000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int frames = 0;
  int errs = 0;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] h;
    case (n)
      4'h0: h = 7'h3F; 4'h1: h = 7'h06; 4'h2: h = 7'h5B; 4'h3: h = 7'h4F;
      4'h4: h = 7'h66; 4'h5: h = 7'h6D; 4'h6: h = 7'h7D; 4'h7: h = 7'h07;
      4'h8: h = 7'h7F; 4'h9: h = 7'h6F; 4'hA: h = 7'h77; 4'hB: h = 7'h7C;
      4'hC: h = 7'h39; 4'hD: h = 7'h5E; 4'hE: h = 7'h79; default: h = 7'h71;
    endcase
    return ~h;
  endfunction

  function automatic logic [3:0] exp_dp(input logic [3:0] dpl);
`ifdef SEG_CAPTURE_DP_EN
    return dpl;
`else
    return 4'b0000 & dpl;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [3:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int n);
    bus.an  = an_v;
    bus.seg = seg_v;
    bus.dp  = dp_v;
    cyc(n);
  endtask

  task automatic blank(input int n);
    show(4'hF, 7'h7F, 1'b1, n);
  endtask

  // dpl bit set = decimal point lit on that digit; scan order AN3 first, AN0 closes
  task automatic scan(input logic [15:0] v, input logic [3:0] dpl, input bit expect_frame);
    for (int d = 3; d >= 0; d--) begin
      if (d == 0 && expect_frame) q.push_back('{val: v, dpf: exp_dp(dpl)});
      show(~(4'b0001 << d), enc(v[d*4 +: 4]), ~dpl[d], 40);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.decode_err) errs++;
      if (bus.frame_valid) begin
        frames++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame got=%h want=none", bus.binary_num);
        end else begin
          e = q.pop_front();
          if (bus.binary_num !== e.val) begin
            bad++;
            $display("FAIL frame_value got=%h want=%h", bus.binary_num, e.val);
          end
          total++;
          if (bus.dp_flags !== e.dpf) begin
            bad++;
            $display("FAIL frame_dp_flags got=%b want=%b", bus.dp_flags, e.dpf);
          end
        end
      end
    end
  end

  initial begin
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    rst_n   = 1'b0;
    cyc(3);
    chk("rst_binary_num", 32'(bus.binary_num), 32'h0);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("rst_decode_err", 32'(bus.decode_err), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_dp_flags", 32'(bus.dp_flags), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    scan(16'h1A2F, 4'b0000, 1'b1);
    scan(16'h1A2F, 4'b0000, 1'b1);
    blank(10);
    chk("scan_frames", 32'(frames), 32'd2);
    chk("scan_locked", 32'(bus.locked), 32'h1);
    chk("scan_no_err", 32'(errs), 32'd0);
    chk("scan_value", 32'(bus.binary_num), 32'h1A2F);

    show(4'b0111, enc(4'h8), 1'b1, 40);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_value", 32'(bus.binary_num), 32'h0);
    chk("midrst_locked", 32'(bus.locked), 32'h0);
    rst_n = 1'b1;
    show(4'b1011, enc(4'h3), 1'b1, 40);
    show(4'b1101, enc(4'h4), 1'b1, 40);
    show(4'b1110, enc(4'h5), 1'b1, 40);
    blank(10);
    chk("partial_no_frame", 32'(frames), 32'd2);
    scan(16'h9345, 4'b0000, 1'b1);
    blank(10);
    chk("full_after_partial", 32'(bus.binary_num), 32'h9345);

    show(4'b0111, enc(4'h1), 1'b1, 40);
    show(4'b1011, enc(4'h2), 1'b1, 40);
    for (int k = 0; k < 15; k++) show(4'b1101, (k % 2 == 0) ? enc(4'h1) : enc(4'h7), 1'b1, 14);
    show(4'b1101, enc(4'h7), 1'b1, 40);
    q.push_back('{val: 16'h1273, dpf: 4'b0000});
    show(4'b1110, enc(4'h3), 1'b1, 40);
    blank(10);
    chk("glitch_value", 32'(bus.binary_num), 32'h1273);
    chk("glitch_frames", 32'(frames), 32'd4);

    show(4'b0111, enc(4'h5), 1'b1, 40);
    show(4'b1011, enc(4'h5), 1'b1, 40);
    show(4'b1101, 7'b1111110, 1'b1, 40);
    show(4'b1110, enc(4'h5), 1'b1, 40);
    blank(10);
    chk("illegal_seg_err", 32'(errs), 32'd1);
    chk("illegal_seg_no_frame", 32'(frames), 32'd4);
    chk("illegal_seg_hold", 32'(bus.binary_num), 32'h1273);

    scan(16'h1A2F, 4'b0000, 1'b1);
    show(4'b1001, enc(4'h8), 1'b1, 60);
    chk("multi_an_err", 32'(errs), 32'd2);
    chk("multi_an_still_locked", 32'(bus.locked), 32'h1);
    blank(2100);
    chk("timeout_unlocked", 32'(bus.locked), 32'h0);
    chk("timeout_value_kept", 32'(bus.binary_num), 32'h1A2F);
    chk("timeout_frames", 32'(frames), 32'd5);

    scan(16'hABCD, 4'b0100, 1'b1);
    blank(10);
    chk("dp_relock", 32'(bus.locked), 32'h1);
    chk("dp_flags", 32'(bus.dp_flags), 32'(exp_dp(4'b0100)));
    chk("dp_value", 32'(bus.binary_num), 32'hABCD);
    chk("final_frames", 32'(frames), 32'd6);
    chk("final_errs", 32'(errs), 32'd2);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
